vtx_scale_xlat: RTL and testbench

- First graphics-pipeline stage, directly downstream of the memory manager.
- Captures per-object scale/translation on object-init pulses and buffers vertices arriving on vertex-init pulses in a FIFO.
- Outputs scaled+translated vertices to the rotation/camera stage over a valid/ready handshake.
- Two parameter banks let a new object be announced while the previous object's vertices are still draining.

---
 rtl/vtx_scale_xlat.sv | 234 +++++++++++++++++++++++
 tb/tb_vtx_scale_xlat.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtx_scale_xlat.sv
`default_nettype none
// ============================================================================
//  Module   : vtx_scale_xlat
//  Purpose  : First graphics-pipeline stage. Captures per-object scale and
//             translation into one of two parameter banks, buffers incoming
//             vertices in a FIFO tagged with their bank, and emits
//             scaled+translated vertices over a valid/ready handshake.
//  Options  : VTX_SCALE_XLAT_SAT_EN - when defined, the shifted product and
//             the final sum saturate to 0x7FFF/0x8000 instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module vtx_scale_xlat #(
   parameter int FIFO_DEPTH = 8,   // vertex FIFO entries, power of two 2..64
   parameter int FRAC_BITS  = 8    // fractional bits of the signed scale
) (
   input  logic                          iClock,
   input  logic                          iReset,
   input  logic                          iEnable,
   input  logic                          iInitObj,
   input  logic                          iInitVtx,
   input  logic [15:0]                   iScaleX,
   input  logic [15:0]                   iScaleY,
   input  logic [15:0]                   iScaleZ,
   input  logic [15:0]                   iTranslX,
   input  logic [15:0]                   iTranslY,
   input  logic [15:0]                   iTranslZ,
   input  logic [15:0]                   iVertexX,
   input  logic [15:0]                   iVertexY,
   input  logic [15:0]                   iVertexZ,
   output logic                          oVtxValid,
   input  logic                          iVtxReady,
   output logic [15:0]                   oVtxX,
   output logic [15:0]                   oVtxY,
   output logic [15:0]                   oVtxZ,
   output logic [$clog2(FIFO_DEPTH):0]   oLevel,
   output logic                          oOverflow,
   output logic                          oObjErr
);

   // -------------------------------------------------------------------------
   // Local sizing
   // -------------------------------------------------------------------------
   localparam int AW = $clog2(FIFO_DEPTH);   // FIFO pointer width
   localparam int LW = AW + 1;               // occupancy / bank-count width
   localparam int EW = 49;                   // {tag, Z, Y, X}
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   // Pipeline condition, used only to sequence the control block
   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,   // nothing buffered, output register idle
      ST_STREAM = 2'd1,   // data present in FIFO and/or output register
      ST_STALL  = 2'd2    // output register held by downstream back-pressure
   } state_t;

   state_t                 state;

   // -------------------------------------------------------------------------
   // Storage
   // -------------------------------------------------------------------------
   logic                   wb;                // bank new vertices are tagged with
   logic [2:0][15:0]       bank_s [2];        // per-bank scale, index 0=X 1=Y 2=Z
   logic [2:0][15:0]       bank_t [2];        // per-bank translation
   logic [LW-1:0]          cnt    [2];        // outstanding vertices per bank
   logic [EW-1:0]          mem    [FIFO_DEPTH];
   logic [AW-1:0]          rd_ptr;
   logic [AW-1:0]          wr_ptr;
   logic                   out_tag;           // bank of the vertex in the output register

   // -------------------------------------------------------------------------
   // Combinational control
   // -------------------------------------------------------------------------
   logic                   obj_ld;
   logic                   vtx_req;
   logic                   wb_next;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   out_free;
   logic                   fifo_pop;
   logic                   fifo_push;
   logic                   vtx_drop;
   logic                   xfer_done;
   logic                   bank_busy;
   logic                   valid_next;
   logic [LW-1:0]          level_next;
   logic [LW-1:0]          cnt_next [2];
   logic [EW-1:0]          head;
   logic                   head_tag;
   logic [2:0][15:0]       head_s;
   logic [2:0][15:0]       head_t;
   logic [15:0]            xf_x;
   logic [15:0]            xf_y;
   logic [15:0]            xf_z;

   // Per-axis transform: (V*S) >>> FRAC_BITS, then + T.
   // The arithmetic shift floors toward -inf; only the low 16 bits are kept
   // unless saturation is compiled in.
   function automatic logic [15:0] xform(
      input logic signed [15:0] v,
      input logic signed [15:0] s,
      input logic signed [15:0] t
   );
      logic signed [31:0] p;
      logic signed [31:0] sh;
      logic signed [15:0] m;
`ifdef VTX_SCALE_XLAT_SAT_EN
      logic        [16:0] sum;
`endif
      p  = v * s;
      sh = p >>> FRAC_BITS;
`ifdef VTX_SCALE_XLAT_SAT_EN
      if (sh > 32'sd32767)
         m = 16'sh7FFF;
      else if (sh < -32'sd32768)
         m = 16'sh8000;
      else
         m = sh[15:0];
      // 17-bit sum: the two top bits disagree exactly when 16 bits overflow
      sum = {m[15], m} + {t[15], t};
      case (sum[16:15])
         2'b01:   xform = 16'h7FFF;
         2'b10:   xform = 16'h8000;
         default: xform = sum[15:0];
      endcase
`else
      m     = sh[15:0];
      xform = m + t;
`endif
   endfunction

   // Decode the handshake, FIFO push/pop and next-state values for this edge
   always_comb begin
      obj_ld      = iInitObj & iEnable;
      vtx_req     = iInitVtx & iEnable;
      // A vertex arriving with an object pulse belongs to the new object
      wb_next     = wb ^ obj_ld;
      fifo_empty  = (oLevel == '0);
      fifo_full   = (oLevel == FULL_LEVEL);
      out_free    = !oVtxValid || iVtxReady;
      fifo_pop    = !fifo_empty && out_free;
      // A full FIFO can still accept when its head leaves on the same edge
      fifo_push   = vtx_req && (!fifo_full || fifo_pop);
      vtx_drop    = vtx_req && fifo_full && !fifo_pop;
      xfer_done   = oVtxValid && iVtxReady;
      // Bank about to be overwritten still has vertices in flight
      bank_busy   = obj_ld && (cnt[wb_next] != '0);

      valid_next  = fifo_pop ? 1'b1 : (xfer_done ? 1'b0 : oVtxValid);
      level_next  = oLevel + LW'(fifo_push) - LW'(fifo_pop);

      cnt_next[0] = cnt[0] + LW'(fifo_push && !wb_next) - LW'(xfer_done && !out_tag);
      cnt_next[1] = cnt[1] + LW'(fifo_push &&  wb_next) - LW'(xfer_done &&  out_tag);

      head        = mem[rd_ptr];
      head_tag    = head[48];
      head_s      = bank_s[head_tag];
      head_t      = bank_t[head_tag];
      xf_x        = xform(head[15:0],  head_s[0], head_t[0]);
      xf_y        = xform(head[31:16], head_s[1], head_t[1]);
      xf_z        = xform(head[47:32], head_s[2], head_t[2]);
   end

   // Vertex FIFO storage; contents are don't-care until written
   always_ff @(posedge iClock) begin
      if (fifo_push)
         mem[wr_ptr] <= {wb_next, iVertexZ, iVertexY, iVertexX};
   end

   // Control, parameter banks, output register, flags and pipeline state
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state     <= ST_EMPTY;
         wb        <= 1'b0;
         bank_s[0] <= '0;
         bank_s[1] <= '0;
         bank_t[0] <= '0;
         bank_t[1] <= '0;
         cnt[0]    <= '0;
         cnt[1]    <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         out_tag   <= 1'b0;
         oVtxValid <= 1'b0;
         oVtxX     <= '0;
         oVtxY     <= '0;
         oVtxZ     <= '0;
         oLevel    <= '0;
         oOverflow <= 1'b0;
         oObjErr   <= 1'b0;
      end else begin
         // Object parameters always go to the bank not currently tagged
         if (obj_ld) begin
            wb              <= wb_next;
            bank_s[wb_next] <= {iScaleZ, iScaleY, iScaleX};
            bank_t[wb_next] <= {iTranslZ, iTranslY, iTranslX};
         end
         if (bank_busy)
            oObjErr <= 1'b1;
         if (vtx_drop)
            oOverflow <= 1'b1;

         if (fifo_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (fifo_pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            out_tag <= head_tag;
            oVtxX   <= xf_x;
            oVtxY   <= xf_y;
            oVtxZ   <= xf_z;
         end
         oVtxValid <= valid_next;
         oLevel    <= level_next;
         cnt[0]    <= cnt_next[0];
         cnt[1]    <= cnt_next[1];

         case (state)
            ST_EMPTY: begin
               if (valid_next || level_next != '0)
                  state <= ST_STREAM;
            end
            ST_STREAM, ST_STALL: begin
               if (oVtxValid && !iVtxReady)
                  state <= ST_STALL;
               else if (!valid_next && level_next == '0)
                  state <= ST_EMPTY;
               else
                  state <= ST_STREAM;
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vtx_scale_xlat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vtx_scale_xlat
//  Purpose  : Self-checking bench for vtx_scale_xlat (table of transform
//             vectors plus hand-written multi-cycle sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vtx_scale_xlat;

   localparam int DEPTH = 8;

   logic                   iClock   = 1'b0;
   logic                   iReset   = 1'b0;
   logic                   iEnable  = 1'b0;
   logic                   iInitObj = 1'b0;
   logic                   iInitVtx = 1'b0;
   logic                   iVtxReady = 1'b0;
   logic [15:0]            iScaleX = '0, iScaleY = '0, iScaleZ = '0;
   logic [15:0]            iTranslX = '0, iTranslY = '0, iTranslZ = '0;
   logic [15:0]            iVertexX = '0, iVertexY = '0, iVertexZ = '0;
   logic                   oVtxValid;
   logic [15:0]            oVtxX, oVtxY, oVtxZ;
   logic [$clog2(DEPTH):0] oLevel;
   logic                   oOverflow;
   logic                   oObjErr;

   int                     n_checks = 0;
   int                     n_fail   = 0;
   int                     n_out    = 0;
   logic [47:0]            exp_q[$];

   typedef struct {
      logic [2:0][15:0] s;   // {Z,Y,X}
      logic [2:0][15:0] t;
      logic [2:0][15:0] v;
      logic [2:0][15:0] e;
   } vec_t;

   vec_t vt [5];

   vtx_scale_xlat #(.FIFO_DEPTH(DEPTH), .FRAC_BITS(8)) dut (
      .iClock   (iClock),
      .iReset   (iReset),
      .iEnable  (iEnable),
      .iInitObj (iInitObj),
      .iInitVtx (iInitVtx),
      .iScaleX  (iScaleX),
      .iScaleY  (iScaleY),
      .iScaleZ  (iScaleZ),
      .iTranslX (iTranslX),
      .iTranslY (iTranslY),
      .iTranslZ (iTranslZ),
      .iVertexX (iVertexX),
      .iVertexY (iVertexY),
      .iVertexZ (iVertexZ),
      .oVtxValid(oVtxValid),
      .iVtxReady(iVtxReady),
      .oVtxX    (oVtxX),
      .oVtxY    (oVtxY),
      .oVtxZ    (oVtxZ),
      .oLevel   (oLevel),
      .oOverflow(oOverflow),
      .oObjErr  (oObjErr)
   );

   always #5 iClock = ~iClock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic load_obj(input logic [2:0][15:0] s, input logic [2:0][15:0] t);
      {iScaleZ, iScaleY, iScaleX}    = s;
      {iTranslZ, iTranslY, iTranslX} = t;
      iInitObj = 1'b1;
      tick();
      iInitObj = 1'b0;
   endtask

   task automatic push_vtx(input logic [2:0][15:0] v, input logic [2:0][15:0] e, input bit track);
      {iVertexZ, iVertexY, iVertexX} = v;
      iInitVtx = 1'b1;
      if (track)
         exp_q.push_back(e);
      tick();
      iInitVtx = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() == 0 && !oVtxValid)
            break;
         tick();
      end
      check(name, 64'({exp_q.size() != 0, oVtxValid}), 64'd0);
   endtask

   // Scoreboard: every completed handshake must match the oldest expectation
   always @(negedge iClock) begin
      if (iReset && oVtxValid && iVtxReady) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_unexpected: got %h expected none", {oVtxZ, oVtxY, oVtxX});
         end else begin
            check("out_vtx", 64'({oVtxZ, oVtxY, oVtxX}), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int base;
      logic [2:0][15:0] s_one;
      logic [2:0][15:0] t_zero;
      s_one  = {16'h0100, 16'h0100, 16'h0100};
      t_zero = '0;

      // ---------------- transform table ({Z,Y,X}) ----------------
      vt[0].s = {16'h0100, 16'h0100, 16'h0100};
      vt[0].t = {16'h0010, 16'h0010, 16'h0010};
      vt[0].v = {16'h0000, 16'hFFF0, 16'h0020};
      vt[0].e = {16'h0010, 16'h0000, 16'h0030};
      vt[1].s = {16'h0180, 16'h0180, 16'h0180};
      vt[1].t = '0;
      vt[1].v = {16'h0002, 16'h0003, 16'hFFFD};
      vt[1].e = {16'h0003, 16'h0004, 16'hFFFB};
      vt[2].s = {16'h8000, 16'h7FFF, 16'h7FFF};
      vt[2].t = {16'h0000, 16'h0001, 16'h0001};
      vt[2].v = {16'h8000, 16'h8000, 16'h7FFF};
`ifdef VTX_SCALE_XLAT_SAT_EN
      vt[2].e = {16'h7FFF, 16'h8001, 16'h7FFF};
`else
      vt[2].e = {16'h0000, 16'h0081, 16'hFF01};
`endif
      vt[3].s = {16'h0100, 16'h0100, 16'h0100};
      vt[3].t = {16'h0000, 16'hFFF0, 16'h0020};
      vt[3].v = {16'h1234, 16'h8005, 16'h7FF0};
`ifdef VTX_SCALE_XLAT_SAT_EN
      vt[3].e = {16'h1234, 16'h8000, 16'h7FFF};
`else
      vt[3].e = {16'h1234, 16'h7FF5, 16'h8010};
`endif
      vt[4].s = {16'hFE00, 16'h0040, 16'hFF80};
      vt[4].t = {16'h0001, 16'h0000, 16'h0100};
      vt[4].v = {16'h0100, 16'h0007, 16'h0003};
      vt[4].e = {16'hFE01, 16'h0001, 16'h00FE};

      // ---------------- reset state ----------------
      repeat (2) @(posedge iClock);
      #1;
      check("rst_valid",    64'(oVtxValid), 64'd0);
      check("rst_level",    64'(oLevel),    64'd0);
      check("rst_flags",    64'({oOverflow, oObjErr}), 64'd0);
      check("rst_vtx",      64'({oVtxZ, oVtxY, oVtxX}), 64'd0);
      @(negedge iClock);
      iReset  = 1'b1;
      iEnable = 1'b1;
      tick();

      // ---------------- table-driven transforms + latency ----------------
      iVtxReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         load_obj(vt[i].s, vt[i].t);
         push_vtx(vt[i].v, vt[i].e, 1'b1);
         check("lat_edge_n",  64'({oVtxValid, oLevel}), 64'({1'b0, 4'd1}));
         tick();
         check("lat_edge_n1", 64'(oVtxValid), 64'd1);
         drain("table_drain");
      end
      check("table_objerr", 64'(oObjErr), 64'd0);

      // ---------------- enable gating ----------------
      iEnable = 1'b0;
      push_vtx(vt[0].v, vt[0].e, 1'b0);
      check("disabled_push", 64'({oVtxValid, oLevel}), 64'd0);
      iEnable = 1'b1;

      // ---------------- bank switching ----------------
      load_obj(s_one, t_zero);
      iVtxReady = 1'b0;
      for (int k = 1; k <= 3; k++)
         push_vtx({16'(k + 16'h20), 16'(k + 16'h10), 16'(k)},
                  {16'(k + 16'h20), 16'(k + 16'h10), 16'(k)}, 1'b1);
      load_obj(s_one, {16'h0100, 16'h0100, 16'h0100});
      check("bank_b_noerr", 64'(oObjErr), 64'd0);
      for (int k = 4; k <= 5; k++)
         push_vtx({16'(k + 16'h20), 16'(k + 16'h10), 16'(k)},
                  {16'(k + 16'h120), 16'(k + 16'h110), 16'(k + 16'h100)}, 1'b1);
      load_obj(s_one, t_zero);
      check("bank_conflict", 64'(oObjErr), 64'd1);
      base = n_out;
      iVtxReady = 1'b1;
      drain("bank_drain");
      check("bank_count", 64'(n_out - base), 64'd5);

      // ---------------- full / overflow ----------------
      load_obj(s_one, t_zero);
      iVtxReady = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         push_vtx({16'(k + 16'h200), 16'(k + 16'h100), 16'(k)},
                  {16'(k + 16'h200), 16'(k + 16'h100), 16'(k)}, k <= 9);
         if (k == 8)
            check("ovf_level7", 64'(oLevel), 64'd7);
         if (k == 9)
            check("ovf_level8", 64'({oOverflow, oLevel}), 64'({1'b0, 4'd8}));
         if (k == 10) begin
            check("ovf_drop",  64'({oOverflow, oLevel}), 64'({1'b1, 4'd8}));
            check("ovf_hold",  64'({oVtxValid, oVtxX}), 64'({1'b1, 16'h0001}));
         end
      end
      tick();
      check("ovf_stable", 64'({oVtxValid, oVtxX}), 64'({1'b1, 16'h0001}));
      base = n_out;
      iVtxReady = 1'b1;
      drain("ovf_drain");
      check("ovf_count", 64'(n_out - base), 64'd9);

      // ---------------- asynchronous reset mid-operation ----------------
      iVtxReady = 1'b0;
      load_obj(s_one, {16'h0005, 16'h0005, 16'h0005});
      for (int k = 1; k <= 5; k++)
         push_vtx({16'(k), 16'(k), 16'(k)}, '0, 1'b0);
      check("pre_rst_state", 64'({oVtxValid, oLevel}), 64'({1'b1, 4'd4}));
      #2;
      iReset = 1'b0;
      #1;
      check("async_rst_out",   64'({oVtxValid, oLevel}), 64'd0);
      check("async_rst_flags", 64'({oOverflow, oObjErr}), 64'd0);
      check("async_rst_vtx",   64'({oVtxZ, oVtxY, oVtxX}), 64'd0);
      exp_q.delete();
      @(negedge iClock);
      iReset    = 1'b1;
      iVtxReady = 1'b1;
      tick();
      push_vtx({16'h7FFF, 16'h5678, 16'h1234}, '0, 1'b1);
      drain("post_rst_zero");
      load_obj(s_one, {16'h0003, 16'h0003, 16'h0003});
      push_vtx({16'h0010, 16'h0010, 16'h0010}, {16'h0013, 16'h0013, 16'h0013}, 1'b1);
      drain("post_rst_obj");
      check("final_queue", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
